pid_mac_seq: RTL and testbench

PID_MAC_SEQ -- requirements
Module: pid_mac_seq

---
 rtl/pid_mac_seq_if.sv | 28 ++
 rtl/pid_mac_seq.sv | 145 ++++++++++++++
 tb/tb_pid_mac_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pid_mac_seq_if.sv
// rtl/pid_mac_seq_if.sv - control, operand and result bundle for the time-shared PID multiply-accumulate
interface pid_mac_seq_if #(
   parameter int ADC_WIDTH = 13,
   parameter int SUM_WIDTH = 3*ADC_WIDTH+1
);
   logic                        act_ctl;
   logic                        sum_en;
   logic        [ADC_WIDTH-1:0] k_p;
   logic        [ADC_WIDTH-1:0] k_i;
   logic        [ADC_WIDTH-1:0] k_d;
   logic signed [ADC_WIDTH-1:0] proportional;
   logic signed [ADC_WIDTH-1:0] integral;
   logic signed [ADC_WIDTH-1:0] derivative;
   logic signed [SUM_WIDTH-1:0] sum;
   logic                        sum_rdy;
   logic                        busy;
   logic                        overrun;

   modport master (
      output act_ctl, sum_en, k_p, k_i, k_d, proportional, integral, derivative,
      input  sum, sum_rdy, busy, overrun
   );

   modport slave (
      input  act_ctl, sum_en, k_p, k_i, k_d, proportional, integral, derivative,
      output sum, sum_rdy, busy, overrun
   );
endinterface

// File: rtl/pid_mac_seq.sv
// rtl/pid_mac_seq.sv - PID sum k_p*p + k_i*i + k_d*d using one shared multiplier over a 6-cycle sequence
// Each product is registered and folded into the accumulator one state later.
module pid_mac_seq #(
   parameter int ADC_WIDTH = 13,
   parameter int SUM_WIDTH = 3*ADC_WIDTH+1
) (
   input  logic          clk,
   input  logic          n_rst,
   pid_mac_seq_if.slave  bus
);
   localparam int PW = 2*ADC_WIDTH+1;

   typedef enum logic [2:0] {IDLE, MUL_P, MUL_I, MUL_D, ACC, DONE} state_e;

   state_e                      state_q, state_d;
   logic        [ADC_WIDTH-1:0] kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
   logic signed [ADC_WIDTH-1:0] ep_q, ep_d, ei_q, ei_d, ed_q, ed_d;
   logic signed [PW-1:0]        prod_q, prod_d;
   logic signed [SUM_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
   logic                        sum_rdy_q, sum_rdy_d;
   logic                        overrun_q, overrun_d;

   logic signed [ADC_WIDTH:0]   mul_a;
   logic signed [ADC_WIDTH-1:0] mul_b;
   logic signed [PW-1:0]        mul_p;
   logic signed [SUM_WIDTH-1:0] prod_ext;

   // Operand select for the single multiplier; gains gain a zero sign bit.
   always_comb begin
      mul_a = signed'({1'b0, kp_q});
      mul_b = ep_q;
      case (state_q)
         MUL_I: begin
            mul_a = signed'({1'b0, ki_q});
            mul_b = ei_q;
         end
         MUL_D: begin
            mul_a = signed'({1'b0, kd_q});
            mul_b = ed_q;
         end
         default: ;
      endcase
      mul_p    = PW'(mul_a) * PW'(mul_b);
      prod_ext = SUM_WIDTH'(prod_q);
   end

   always_comb begin
      state_d   = state_q;
      kp_d      = kp_q;
      ki_d      = ki_q;
      kd_d      = kd_q;
      ep_d      = ep_q;
      ei_d      = ei_q;
      ed_d      = ed_q;
      prod_d    = prod_q;
      acc_d     = acc_q;
      sum_d     = sum_q;
      sum_rdy_d = 1'b0;
      overrun_d = overrun_q;

      // Losing act_ctl wins over everything, including a pending start.
      if (!bus.act_ctl) begin
         state_d = IDLE;
         sum_d   = '0;
         acc_d   = '0;
      end else begin
         if (state_q != IDLE && bus.sum_en) begin
            overrun_d = 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (bus.sum_en) begin
                  kp_d    = bus.k_p;
                  ki_d    = bus.k_i;
                  kd_d    = bus.k_d;
                  ep_d    = bus.proportional;
                  ei_d    = bus.integral;
                  ed_d    = bus.derivative;
                  acc_d   = '0;
                  state_d = MUL_P;
               end
            end
            MUL_P: begin
               prod_d  = mul_p;
               state_d = MUL_I;
            end
            MUL_I: begin
               prod_d  = mul_p;
               acc_d   = acc_q + prod_ext;
               state_d = MUL_D;
            end
            MUL_D: begin
               prod_d  = mul_p;
               acc_d   = acc_q + prod_ext;
               state_d = ACC;
            end
            ACC: begin
               acc_d   = acc_q + prod_ext;
               state_d = DONE;
            end
            DONE: begin
               sum_d     = acc_q;
               sum_rdy_d = 1'b1;
               state_d   = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         kp_q      <= '0;
         ki_q      <= '0;
         kd_q      <= '0;
         ep_q      <= '0;
         ei_q      <= '0;
         ed_q      <= '0;
         prod_q    <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         sum_rdy_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         kp_q      <= kp_d;
         ki_q      <= ki_d;
         kd_q      <= kd_d;
         ep_q      <= ep_d;
         ei_q      <= ei_d;
         ed_q      <= ed_d;
         prod_q    <= prod_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         sum_rdy_q <= sum_rdy_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.sum     = sum_q;
   assign bus.sum_rdy = sum_rdy_q;
   assign bus.busy    = (state_q != IDLE);
   assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_pid_mac_seq.sv
// tb/tb_pid_mac_seq.sv - directed and randomized bench for pid_mac_seq against a cycle-level result model
module tb_pid_mac_seq;
   localparam int AW = 13;
   localparam int SW = 3*AW+1;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   pid_mac_seq_if #(.ADC_WIDTH(AW), .SUM_WIDTH(SW)) bus();

   pid_mac_seq #(.ADC_WIDTH(AW), .SUM_WIDTH(SW)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   int     n_vec = 0;
   int     n_err = 0;
   bit     m_busy, m_rdy, m_ovr;
   int     m_cnt;
   longint m_sum, m_pend;

   task automatic check_val(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_ops(input int kp, input int ki, input int kd,
                          input int p, input int i, input int d);
      bus.k_p          = kp[AW-1:0];
      bus.k_i          = ki[AW-1:0];
      bus.k_d          = kd[AW-1:0];
      bus.proportional = p[AW-1:0];
      bus.integral     = i[AW-1:0];
      bus.derivative   = d[AW-1:0];
   endtask

   // One clock: the model sees the same inputs as the DUT, outputs are compared 1 time unit later.
   task automatic tick();
      @(posedge clk);
      if (!n_rst) begin
         m_busy = 0; m_rdy = 0; m_ovr = 0; m_sum = 0; m_cnt = 0;
      end else begin
         m_rdy = 0;
         if (!bus.act_ctl) begin
            m_busy = 0;
            m_sum  = 0;
         end else if (!m_busy) begin
            if (bus.sum_en) begin
               m_busy = 1;
               m_cnt  = 0;
               m_pend = longint'(bus.k_p) * longint'(bus.proportional)
                      + longint'(bus.k_i) * longint'(bus.integral)
                      + longint'(bus.k_d) * longint'(bus.derivative);
            end
         end else begin
            if (bus.sum_en) m_ovr = 1;
            m_cnt++;
            if (m_cnt == 5) begin
               m_busy = 0;
               m_sum  = m_pend;
               m_rdy  = 1;
            end
         end
      end
      #1;
      check_val("sum",     longint'(bus.sum),     m_sum);
      check_val("sum_rdy", longint'(bus.sum_rdy), longint'(m_rdy));
      check_val("busy",    longint'(bus.busy),    longint'(m_busy));
      check_val("overrun", longint'(bus.overrun), longint'(m_ovr));
   endtask

   task automatic run_calc();
      bus.sum_en = 1'b1;
      tick();
      bus.sum_en = 1'b0;
      repeat (5) tick();
   endtask

   initial begin
      bus.act_ctl = 1'b0;
      bus.sum_en  = 1'b0;
      set_ops(0, 0, 0, 0, 0, 0);
      m_busy = 0; m_rdy = 0; m_ovr = 0; m_sum = 0; m_cnt = 0; m_pend = 0;

      n_rst = 1'b0;
      repeat (2) tick();
      n_rst = 1'b1;
      tick();

      bus.act_ctl = 1'b1;
      set_ops(2, 1, 0, 100, -50, 7);
      run_calc();
      check_val("basic_150", longint'(bus.sum), 150);
      tick();

      set_ops(8191, 8191, 8191, -4096, -4096, -4096);
      run_calc();
      check_val("max_neg", longint'(bus.sum), -100651008);
      set_ops(8191, 8191, 8191, 4095, 4095, 4095);
      run_calc();
      check_val("max_pos", longint'(bus.sum), 100626435);

      set_ops(3, 5, 2, -7, 11, -1000);
      bus.sum_en = 1'b1;
      tick();
      bus.sum_en = 1'b0;
      set_ops(100, 200, 300, 1, 2, 3);
      tick();
      bus.sum_en = 1'b1;
      tick();
      bus.sum_en = 1'b0;
      repeat (3) tick();
      check_val("captured_ops", longint'(bus.sum), -1966);
      check_val("overrun_set", longint'(bus.overrun), 1);

      set_ops(17, 4000, 9, -3, 2047, -4096);
      bus.sum_en = 1'b1;
      repeat (20) tick();
      bus.sum_en = 1'b0;
      repeat (6) tick();

      set_ops(7, 7, 7, 1000, -1000, 500);
      bus.sum_en = 1'b1;
      tick();
      bus.sum_en = 1'b0;
      repeat (2) tick();
      bus.act_ctl = 1'b0;
      tick();
      check_val("abort_busy", longint'(bus.busy), 0);
      bus.act_ctl = 1'b1;
      tick();
      run_calc();
      check_val("after_abort", longint'(bus.sum), 3500);

      set_ops(8191, 1, 8191, -4096, 5, 4095);
      bus.sum_en = 1'b1;
      tick();
      bus.sum_en = 1'b0;
      repeat (2) tick();
      n_rst = 1'b0;
      tick();
      check_val("rst_sum", longint'(bus.sum), 0);
      n_rst = 1'b1;
      tick();
      run_calc();
      check_val("after_rst", longint'(bus.sum), -33550336 + 5 + 33542145);

      repeat (3000) begin
         set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
         bus.sum_en  = ($urandom % 100) < 40;
         bus.act_ctl = ($urandom % 100) < 96;
         n_rst       = ($urandom % 200) != 0;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
